usr_seq_shifter: RTL and testbench

Parametrised sequential universal shift register, the next generation of the team's 8-bit universal shift register. Adds configurable width, multi-bit shifts of a programmable amount executed one bit per clock, arithmetic and rotate modes, independent left/right serial inputs and outputs, and a start/busy/done handshake. It sits in the datapath wherever a controller needs serialise/deserialise or barrel-style shifts without a combinational barrel shifter.

---
 rtl/usr_pkg.sv | 34 +++
 rtl/usr_seq_shifter_if.sv | 34 +++
 rtl/usr_shift_step.sv | 34 +++
 rtl/usr_seq_shifter.sv | 101 ++++++++++
 tb/tb_usr_seq_shifter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: shared types for the sequential universal shift register.
//   op_e    - 3-bit command opcodes
//   state_e - controller states (IDLE, SHIFT)
//   op_is_shift() - true for opcodes that run the multi-bit shift sequence
// Optional feature macro: USR_ROTATE_EN (enables ROL/ROR).
package usr_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_SLL  = 3'b001,
    OP_SRL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_SRA  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Without rotate support ROL/ROR fall through to the "N=0" path.
  function automatic logic op_is_shift(op_e op);
    logic r;
    r = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`ifdef USR_ROTATE_EN
    r = r || (op == OP_ROL) || (op == OP_ROR);
`endif
    return r;
  endfunction

endpackage

// File: rtl/usr_seq_shifter_if.sv
// usr_seq_shifter_if: command/data bundle for usr_seq_shifter.
//   start, op, amount, d   - command strobe, opcode, shift count, load data
//   sin_l, sin_r           - serial inputs at MSB / LSB side
//   q, sout_l, sout_r      - register contents and serial outputs
//   busy, done             - SHIFT-state flag and one-cycle completion pulse
// Modports: master (controller side), slave (shifter side).
interface usr_seq_shifter_if
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
);
  logic             start;
  op_e              op;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amount, d, sin_l, sin_r,
    input  q, sout_l, sout_r, busy, done
  );

  modport slave (
    input  start, op, amount, d, sin_l, sin_r,
    output q, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/usr_shift_step.sv
// usr_shift_step: combinational single-bit step of the universal shifter.
//   op     - opcode selecting the step kind
//   q      - current register value
//   sin_l  - fill bit for logical right shift
//   sin_r  - fill bit for left shift
//   q_next - value after one step (unchanged for non-shift opcodes)
// Optional feature macro: USR_ROTATE_EN (enables ROL/ROR steps).
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] q,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_SLL:  q_next = {q[WIDTH-2:0], sin_r};
      OP_SRL:  q_next = {sin_l, q[WIDTH-1:1]};
      OP_SRA:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
`endif
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/usr_seq_shifter.sv
// usr_seq_shifter: parametrised sequential universal shift register.
// Multi-bit shifts execute one bit per clock with a start/busy/done handshake.
//   clk   - clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - usr_seq_shifter_if.slave (command, serial I/O, q, busy, done)
// Optional feature macro: USR_ROTATE_EN (ROL/ROR; otherwise they act as N=0).
module usr_seq_shifter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               reset,
  usr_seq_shifter_if.slave  bus
);

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  state_e           state;
  op_e              op_q;
  op_e              step_op;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] n_clamp;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             done_r;

  assign n_clamp = (bus.amount > AMT_MAX) ? AMT_MAX : bus.amount;

  // The first shift happens on the accepting edge, so the step uses the live
  // opcode in IDLE and the latched one while shifting.
  assign step_op = (state == SHIFT) ? op_q : bus.op;

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .op     (step_op),
    .q      (q_r),
    .sin_l  (bus.sin_l),
    .sin_r  (bus.sin_r),
    .q_next (q_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      remaining <= '0;
      q_r       <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_LOAD: begin
                q_r    <= bus.d;
                done_r <= 1'b1;
              end
              OP_CLR: begin
                q_r    <= '0;
                done_r <= 1'b1;
              end
              default: begin
                if (op_is_shift(bus.op) && (n_clamp != '0)) begin
                  q_r <= q_next;
                  if (n_clamp == AMT_ONE) begin
                    done_r <= 1'b1;
                  end else begin
                    state     <= SHIFT;
                    op_q      <= bus.op;
                    remaining <= n_clamp - AMT_ONE;
                  end
                end else begin
                  done_r <= 1'b1;
                end
              end
            endcase
          end
        end
        SHIFT: begin
          q_r       <= q_next;
          remaining <= remaining - AMT_ONE;
          if (remaining == AMT_ONE) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q      = q_r;
  assign bus.sout_l = q_r[WIDTH-1];
  assign bus.sout_r = q_r[0];
  assign bus.busy   = (state == SHIFT);
  assign bus.done   = done_r;

endmodule

// File: tb/tb_usr_seq_shifter.sv
// tb_usr_seq_shifter: self-checking bench for usr_seq_shifter (WIDTH=8).
// Expected values come from a closed-form model: the result of k shifts is
// computed directly with integer shifts/masks rather than stepping bit by bit.
// Honours USR_ROTATE_EN the same way as the design.
module tb_usr_seq_shifter;
  import usr_pkg::*;

  localparam int W    = 8;
  localparam int AW   = 4;
  localparam int MASK = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  usr_seq_shifter_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  usr_seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int ref_q  = 0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic bit rot_en();
`ifdef USR_ROTATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Number of shift edges a command performs.
  function automatic int shift_count(op_e op, int amt);
    int n;
    n = (amt > W) ? W : amt;
    if (op == OP_SLL || op == OP_SRL || op == OP_SRA) return n;
    if ((op == OP_ROL || op == OP_ROR) && rot_en()) return n;
    return 0;
  endfunction

  // Register value after k shifts from q0 with constant serial inputs.
  function automatic int model_after(op_e op, int q0, int k, bit sl, bit sr);
    int fill_hi;
    int fill_lo;
    fill_hi = MASK & ~(MASK >> k);
    fill_lo = (1 << k) - 1;
    case (op)
      OP_SLL:  return ((q0 << k) | (sr ? fill_lo : 0)) & MASK;
      OP_SRL:  return (q0 >> k) | (sl ? fill_hi : 0);
      OP_SRA:  return (q0 >> k) | ((((q0 >> (W - 1)) & 1) != 0) ? fill_hi : 0);
      OP_ROL:  return ((q0 << k) | (q0 >> (W - k))) & MASK;
      OP_ROR:  return ((q0 >> k) | (q0 << (W - k))) & MASK;
      default: return q0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and follows it edge by edge until completion.
  task automatic run_cmd(string tag, op_e op, int amt, int dv, bit sl, bit sr, bit noise);
    int n;
    int q0;
    int expq;
    bit eb;
    bit ed;
    n  = shift_count(op, amt);
    q0 = ref_q;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.amount = amt[AW-1:0];
    bus.d      = dv[W-1:0];
    bus.sin_l  = sl;
    bus.sin_r  = sr;
    tick();
    bus.start = 1'b0;
    if (n == 0) begin
      expq = (op == OP_LOAD) ? (dv & MASK) : (op == OP_CLR) ? 0 : q0;
      checks++;
      if (bus.q !== expq[W-1:0] || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s single: got q=%h done=%b busy=%b, expected q=%h done=1 busy=0",
                 tag, bus.q, bus.done, bus.busy, expq[W-1:0]);
      end
      ref_q = expq;
      return;
    end
    expq = q0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) tick();
      expq = model_after(op, q0, k, sl, sr);
      eb = (k < n);
      ed = (k == n);
      checks++;
      if (bus.q !== expq[W-1:0] || bus.busy !== eb || bus.done !== ed) begin
        errors++;
        $display("FAIL %s edge %0d: got q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                 tag, k, bus.q, bus.busy, bus.done, expq[W-1:0], eb, ed);
      end
      checks++;
      if (bus.sout_l !== expq[W-1] || bus.sout_r !== expq[0]) begin
        errors++;
        $display("FAIL %s sout edge %0d: got l=%b r=%b, expected l=%b r=%b",
                 tag, k, bus.sout_l, bus.sout_r, expq[W-1], expq[0]);
      end
      if (noise && k < n) begin
        bus.start  = 1'b1;
        bus.op     = op_e'($urandom_range(0, 7));
        bus.amount = AW'($urandom_range(0, 15));
        bus.d      = W'($urandom_range(0, 255));
      end
    end
    bus.start = 1'b0;
    ref_q = expq;
  endtask

  task automatic idle_check(string tag);
    tick();
    checks++;
    if (bus.q !== ref_q[W-1:0] || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got q=%h done=%b busy=%b, expected q=%h done=0 busy=0",
               tag, bus.q, bus.done, bus.busy, ref_q[W-1:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: got q=%h busy=%b done=%b, expected 00/0/0", bus.q, bus.busy, bus.done);
    end
    run_cmd("reset_load", OP_LOAD, 0, 8'h5A, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got q=%h busy=%b done=%b, expected 00/0/0", bus.q, bus.busy, bus.done);
    end
    reset = 1'b0;
    ref_q = 0;
    idle_check("reset_after");
  endtask

  task automatic test_load();
    run_cmd("load", OP_LOAD, 0, 8'hA5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.q !== 8'hA5) begin
      errors++;
      $display("FAIL load_value: got %h expected a5", bus.q);
    end
    idle_check("load");
  endtask

  task automatic test_sll();
    run_cmd("sll3", OP_SLL, 3, 0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.q !== 8'h2F) begin
      errors++;
      $display("FAIL sll3_final: got %h expected 2f", bus.q);
    end
    idle_check("sll3");
  endtask

  task automatic test_sra_srl_clamp();
    run_cmd("load90", OP_LOAD, 0, 8'h90, 1'b0, 1'b0, 1'b0);
    run_cmd("sra2", OP_SRA, 2, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.q !== 8'hE4) begin
      errors++;
      $display("FAIL sra2_final: got %h expected e4", bus.q);
    end
    run_cmd("srl12", OP_SRL, 12, 0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.q !== 8'h00) begin
      errors++;
      $display("FAIL srl12_final: got %h expected 00", bus.q);
    end
    idle_check("srl12");
  endtask

  task automatic test_rotate();
    logic [7:0] want;
    want = rot_en() ? 8'h0C : 8'h81;
    run_cmd("load81", OP_LOAD, 0, 8'h81, 1'b0, 1'b0, 1'b0);
    run_cmd("rol3", OP_ROL, 3, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.q !== want) begin
      errors++;
      $display("FAIL rol3_final: got %h expected %h", bus.q, want);
    end
    run_cmd("ror5", OP_ROR, 5, 0, 1'b1, 1'b1, 1'b0);
    idle_check("rotate");
  endtask

  task automatic test_reset_mid();
    run_cmd("loadff", OP_LOAD, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    bus.start  = 1'b1;
    bus.op     = OP_SRL;
    bus.amount = 4'd6;
    bus.sin_l  = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.q !== 8'h3F || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got q=%h busy=%b, expected 3f busy=1", bus.q, bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got q=%h busy=%b done=%b, expected 00/0/0", bus.q, bus.busy, bus.done);
    end
    #1 reset = 1'b0;
    ref_q = 0;
    for (int i = 0; i < 6; i++) idle_check("midreset_nodone");
    run_cmd("load3c", OP_LOAD, 0, 8'h3C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.q !== 8'h3C) begin
      errors++;
      $display("FAIL load3c: got %h expected 3c", bus.q);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_sll", OP_SLL, 2, 0, 1'b0, 1'b0, 1'b0);
    run_cmd("b2b_srl", OP_SRL, 1, 0, 1'b1, 1'b0, 1'b0);
    run_cmd("b2b_nop", OP_NOP, 5, 0, 1'b0, 1'b0, 1'b0);
    run_cmd("b2b_sra0", OP_SRA, 0, 0, 1'b0, 1'b0, 1'b0);
    run_cmd("b2b_clr", OP_CLR, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    idle_check("b2b");
  endtask

  task automatic test_random();
    op_e op;
    for (int i = 0; i < 40; i++) begin
      op = op_e'($urandom_range(0, 7));
      run_cmd("rand", op, $urandom_range(0, 15), $urandom_range(0, 255),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check("rand");
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = OP_NOP;
    bus.amount = '0;
    bus.d      = '0;
    bus.sin_l  = 1'b0;
    bus.sin_r  = 1'b0;
    test_reset();
    test_load();
    test_sll();
    test_sra_srl_clamp();
    test_rotate();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
